// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: FSM encodings, forward selects,
// and a register-match helper that never matches $0.
package pipe_ctrl_pkg;

  localparam logic ST_RUN     = 1'b0;
  localparam logic ST_MD_WAIT = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic reg_match(input logic [4:0] producer, input logic [4:0] consumer);
    return (producer != REG_ZERO) && (producer == consumer);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one ALU source; MEM result beats WB.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_reg_i,
  input  logic [4:0] mem_waddr_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] wb_waddr_i,
  input  logic       wb_regwrite_i,
  output logic [1:0] fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (mem_regwrite_i && reg_match(mem_waddr_i, src_reg_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (wb_regwrite_i && reg_match(wb_waddr_i, src_reg_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush/forwarding sequencer for the 5-stage pipeline, with a MULT/DIV freeze FSM.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 4
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_waddr,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic       ex_redirect,
  input  logic       ex_md_start,
  input  logic [4:0] mem_waddr,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_waddr,
  input  logic       wb_regwrite,
  output logic       pc_we,
  output logic       if_id_we,
  output logic       id_ex_we,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] md_cycles
`endif
);

  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

  logic       state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;
  logic       load_use;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  fwd_unit u_fwd_a (
    .src_reg_i      (ex_rs),
    .mem_waddr_i    (mem_waddr),
    .mem_regwrite_i (mem_regwrite),
    .wb_waddr_i     (wb_waddr),
    .wb_regwrite_i  (wb_regwrite),
    .fwd_sel_o      (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src_reg_i      (ex_rt),
    .mem_waddr_i    (mem_waddr),
    .mem_regwrite_i (mem_regwrite),
    .wb_waddr_i     (wb_waddr),
    .wb_regwrite_i  (wb_regwrite),
    .fwd_sel_o      (fwd_b_raw)
  );

  assign fwd_a = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b = rst ? FWD_RF : fwd_b_raw;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    load_use     = ex_memread && ex_regwrite &&
                   ((id_uses_rs && reg_match(ex_waddr, id_rs)) ||
                    (id_uses_rt && reg_match(ex_waddr, id_rt)));

    if (!rst) begin
      md_busy = (state_q == ST_MD_WAIT);
      if (en) begin
        if (state_q == ST_RUN) begin
          // Redirect squashes the ID instruction, so a coincident load-use is moot.
          if (ex_redirect) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (ex_md_start) begin
            ex_mem_flush = 1'b1;
            state_d      = ST_MD_WAIT;
            md_cnt_d     = MD_LOAD;
          end else if (load_use) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
            id_ex_we = 1'b1;
          end
        end else begin
          ex_mem_flush = 1'b1;
          if (md_cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            md_cnt_d = md_cnt_q - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample together.
    if (rst) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
      md_cycles    <= '0;
    end else if (en) begin
      if (!pc_we) stall_cycles <= stall_cycles + 1'b1;
      if (state_q == ST_RUN && ex_redirect) flush_events <= flush_events + 1'b1;
      if (state_q == ST_MD_WAIT) md_cycles <= md_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected control vectors are queued as
// stimulus is driven and compared at the following falling edge.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_waddr;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_redirect;
    logic       ex_md_start;
    logic [4:0] mem_waddr;
    logic       mem_regwrite;
    logic [4:0] wb_waddr;
    logic       wb_regwrite;
  } stim_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, md_busy}
  localparam logic [6:0] C_ZERO   = 7'b000_000_0;
  localparam logic [6:0] C_NORMAL = 7'b111_000_0;
  localparam logic [6:0] C_LU     = 7'b001_010_0;
  localparam logic [6:0] C_REDIR  = 7'b111_110_0;
  localparam logic [6:0] C_MDS    = 7'b000_001_0;
  localparam logic [6:0] C_MDW    = 7'b000_001_1;
  localparam logic [6:0] C_FROZEN = 7'b000_000_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t stim;
  logic pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [10:0] obs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, md_cycles;
`endif

  sb_t sb[$];
  int checks = 0;
  int failures = 0;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .rst          (stim.rst),
    .en           (stim.en),
    .id_rs        (stim.id_rs),
    .id_rt        (stim.id_rt),
    .id_uses_rs   (stim.id_uses_rs),
    .id_uses_rt   (stim.id_uses_rt),
    .ex_rs        (stim.ex_rs),
    .ex_rt        (stim.ex_rt),
    .ex_waddr     (stim.ex_waddr),
    .ex_regwrite  (stim.ex_regwrite),
    .ex_memread   (stim.ex_memread),
    .ex_redirect  (stim.ex_redirect),
    .ex_md_start  (stim.ex_md_start),
    .mem_waddr    (stim.mem_waddr),
    .mem_regwrite (stim.mem_regwrite),
    .wb_waddr     (stim.wb_waddr),
    .wb_regwrite  (stim.wb_regwrite),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .id_ex_we     (id_ex_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .md_busy      (md_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .md_cycles    (md_cycles)
`endif
  );

  assign obs = {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush,
                md_busy, fwd_a, fwd_b};

  function automatic stim_t idle();
    stim_t s;
    s    = '0;
    s.en = 1'b1;
    return s;
  endfunction

  function automatic stim_t load_use_rs();
    stim_t s;
    s             = idle();
    s.ex_memread  = 1'b1;
    s.ex_regwrite = 1'b1;
    s.ex_waddr    = 5'd8;
    s.id_uses_rs  = 1'b1;
    s.id_rs       = 5'd8;
    return s;
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation.
  task automatic drive(input stim_t s, input string nm, input logic [10:0] e);
    @(posedge clk);
    #1;
    stim = s;
    sb.push_back('{nm, e});
  endtask

  task automatic test_reset();
    stim_t s;
    sb_t   got;
    s              = idle();
    s.rst          = 1'b1;
    s.ex_md_start  = 1'b1;
    s.ex_rs        = 5'd5;
    s.mem_waddr    = 5'd5;
    s.mem_regwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(s, "reset_hold", {C_ZERO, 4'b0000});
      else       drive(idle(), "reset_release_run", {C_NORMAL, 4'b0000});
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (obs !== got.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", got.name, obs, got.exp);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    sb_t   got;
    for (int i = 0; i < 6; i++) begin
      s = load_use_rs();
      case (i)
        0: drive(s, "lu_rs_stall", {C_LU, 4'b0000});
        1: begin s.ex_memread = 1'b0; drive(s, "lu_release", {C_NORMAL, 4'b0000}); end
        2: begin s.ex_waddr = 5'd0; s.id_rs = 5'd0; drive(s, "lu_reg0_no_stall", {C_NORMAL, 4'b0000}); end
        3: begin s.id_uses_rs = 1'b0; s.id_uses_rt = 1'b1; s.id_rt = 5'd8; s.id_rs = 5'd3;
                 drive(s, "lu_rt_stall", {C_LU, 4'b0000}); end
        4: begin s.id_uses_rs = 1'b0; drive(s, "lu_rs_unused", {C_NORMAL, 4'b0000}); end
        default: begin s.ex_regwrite = 1'b0; drive(s, "lu_no_regwrite", {C_NORMAL, 4'b0000}); end
      endcase
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (obs !== got.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", got.name, obs, got.exp);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t s;
    sb_t   got;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin s = load_use_rs(); s.ex_redirect = 1'b1;
                 drive(s, "redirect_over_lu", {C_REDIR, 4'b0000}); end
        1: begin s = idle(); s.ex_redirect = 1'b1; s.ex_md_start = 1'b1;
                 drive(s, "redirect_over_md", {C_REDIR, 4'b0000}); end
        default: drive(idle(), "redirect_no_md_wait", {C_NORMAL, 4'b0000});
      endcase
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (obs !== got.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", got.name, obs, got.exp);
      end
    end
  endtask

  task automatic test_md_wait();
    stim_t s;
    sb_t   got;
    // Plain MULT: start + 3 wait cycles, with a redirect ignored mid-wait.
    // Second MULT: en dropped for 2 cycles mid-wait, stretching the freeze.
    for (int i = 0; i < 12; i++) begin
      s = idle();
      case (i)
        0, 5: begin s.ex_md_start = 1'b1; drive(s, "md_start", {C_MDS, 4'b0000}); end
        1, 6: drive(s, "md_wait1", {C_MDW, 4'b0000});
        2: begin s.ex_redirect = 1'b1; s.ex_md_start = 1'b1; drive(s, "md_wait2_redirect", {C_MDW, 4'b0000}); end
        3, 10: drive(s, "md_wait3", {C_MDW, 4'b0000});
        4, 11: drive(s, "md_release", {C_NORMAL, 4'b0000});
        7, 8: begin s.en = 1'b0; s.ex_redirect = 1'b1; drive(s, "md_frozen", {C_FROZEN, 4'b0000}); end
        default: drive(s, "md_wait2", {C_MDW, 4'b0000});
      endcase
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (obs !== got.exp) begin
        failures++;
        $display("FAIL %s[%0d]: got %b expected %b", got.name, i, obs, got.exp);
      end
    end
  endtask

  task automatic test_forwarding();
    stim_t s;
    sb_t   got;
    for (int i = 0; i < 6; i++) begin
      s = idle();
      case (i)
        0: begin s.ex_rs = 5'd5; s.mem_waddr = 5'd5; s.mem_regwrite = 1'b1;
                 s.wb_waddr = 5'd5; s.wb_regwrite = 1'b1;
                 drive(s, "fwd_mem_priority", {C_NORMAL, 2'b10, 2'b00}); end
        1: begin s.ex_rs = 5'd5; s.mem_waddr = 5'd5; s.wb_waddr = 5'd5; s.wb_regwrite = 1'b1;
                 drive(s, "fwd_wb", {C_NORMAL, 2'b01, 2'b00}); end
        2: begin s.mem_regwrite = 1'b1; s.wb_regwrite = 1'b1;
                 drive(s, "fwd_reg0", {C_NORMAL, 2'b00, 2'b00}); end
        3: begin s.ex_rs = 5'd9; s.ex_rt = 5'd7; s.mem_waddr = 5'd7; s.mem_regwrite = 1'b1;
                 s.wb_waddr = 5'd9; s.wb_regwrite = 1'b1;
                 drive(s, "fwd_split", {C_NORMAL, 2'b01, 2'b10}); end
        4: begin s.ex_rs = 5'd4; s.ex_rt = 5'd4; s.mem_waddr = 5'd4; s.wb_waddr = 5'd4;
                 drive(s, "fwd_no_regwrite", {C_NORMAL, 2'b00, 2'b00}); end
        default: begin s.en = 1'b0; s.ex_rs = 5'd5; s.ex_rt = 5'd6; s.mem_waddr = 5'd5;
                 s.mem_regwrite = 1'b1; s.wb_waddr = 5'd6; s.wb_regwrite = 1'b1;
                 drive(s, "fwd_while_disabled", {C_ZERO, 2'b10, 2'b01}); end
      endcase
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (obs !== got.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", got.name, obs, got.exp);
      end
    end
  endtask

  task automatic test_reset_mid_md();
    stim_t s;
    sb_t   got;
    for (int i = 0; i < 7; i++) begin
      s = idle();
      case (i)
        0: begin s.ex_md_start = 1'b1; drive(s, "rmd_start", {C_MDS, 4'b0000}); end
        1: drive(s, "rmd_wait1", {C_MDW, 4'b0000});
        2: begin s.rst = 1'b1; drive(s, "rmd_reset", {C_ZERO, 4'b0000}); end
        3: drive(s, "rmd_run", {C_NORMAL, 4'b0000});
        4: drive(load_use_rs(), "rmd_lu", {C_LU, 4'b0000});
        5: begin s.ex_redirect = 1'b1; drive(s, "rmd_redirect", {C_REDIR, 4'b0000}); end
        default: drive(s, "rmd_idle", {C_NORMAL, 4'b0000});
      endcase
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (obs !== got.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", got.name, obs, got.exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (i == 3) begin
        checks++;
        if ({stall_cycles, flush_events, md_cycles} !== 96'd0) begin
          failures++;
          $display("FAIL perf_after_reset: got %0d/%0d/%0d expected 0/0/0",
                   stall_cycles, flush_events, md_cycles);
        end
      end
      if (i == 6) begin
        checks++;
        if (stall_cycles !== 32'd1 || flush_events !== 32'd1 || md_cycles !== 32'd0) begin
          failures++;
          $display("FAIL perf_counts: got %0d/%0d/%0d expected 1/1/0",
                   stall_cycles, flush_events, md_cycles);
        end
      end
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    stim     = idle();
    stim.rst = 1'b1;
    test_reset();
    test_load_use();
    test_redirect();
    test_md_wait();
    test_forwarding();
    test_reset_mid_md();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
